// File: rtl/seq_ctrl_param_if.sv
// Handshake/bus bundle for seq_ctrl_param: control and programming inputs, registered outputs.
// master drives the controls, slave is the sequence controller.
interface seq_ctrl_param_if #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
);
  logic             start;
  logic             abort;
  logic             en;
  logic             mode;
  logic [AW:0]      len;
  logic             prog_we;
  logic [AW-1:0]    prog_addr;
  logic [WIDTH-1:0] prog_data;
  logic [WIDTH-1:0] count;
  logic             clear;
  logic             busy;
  logic             done;
  logic             wrap;

  modport master (
    output start, abort, en, mode, len, prog_we, prog_addr, prog_data,
    input  count, clear, busy, done, wrap
  );

  modport slave (
    input  start, abort, en, mode, len, prog_we, prog_addr, prog_data,
    output count, clear, busy, done, wrap
  );
endinterface

// File: rtl/seq_ctrl_param.sv
// Programmable sequence controller: steps a counter through the first len entries of a
// DEPTH-entry table, in loop or one-shot mode, with restart, abort and run-time reprogramming.
module seq_ctrl_param #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input logic             clk,
  input logic             rst_n,
  seq_ctrl_param_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StClear, StRun, StDone} state_e;

  localparam logic [AW:0] LenOne = (AW+1)'(1);
  localparam logic [AW:0] LenMax = (AW+1)'(DEPTH);

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_table [DEPTH];
  logic [WIDTH-1:0] r_count, w_count_d;
  logic             r_clear, w_clear_d;
  logic             r_busy, w_busy_d;
  logic             r_done, w_done_d;
  logic             r_wrap, w_wrap_d;
  logic [AW-1:0]    r_idx, w_idx_d, w_idx_inc;
  logic             r_mode, w_mode_d;
  logic [AW:0]      r_len, w_len_d, w_len_clamp;
  logic             w_last;
  logic             w_addr_ok;

  assign w_idx_inc = r_idx + AW'(1);
  assign w_last    = ({1'b0, r_idx} == (r_len - LenOne));
  assign w_addr_ok = (32'(bus.prog_addr) < DEPTH);

  always_comb begin
    if (bus.len == '0) begin
      w_len_clamp = LenOne;
    end else if (32'(bus.len) > DEPTH) begin
      w_len_clamp = LenMax;
    end else begin
      w_len_clamp = bus.len;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next state: abort beats start, start beats everything else
  always_comb begin
    w_state_d = r_state;
    if (bus.abort) begin
      w_state_d = StIdle;
    end else if (bus.start) begin
      w_state_d = StClear;
    end else begin
      case (r_state)
        StClear: w_state_d = StRun;
        StRun:   if (bus.en && w_last && r_mode) w_state_d = StDone;
        default: w_state_d = r_state;
      endcase
    end
  end

  // Output next values, all registered below
  always_comb begin
    w_count_d = r_count;
    w_clear_d = r_clear;
    w_busy_d  = r_busy;
    w_done_d  = r_done;
    w_wrap_d  = 1'b0;
    w_idx_d   = r_idx;
    w_mode_d  = r_mode;
    w_len_d   = r_len;
    case (w_state_d)
      StIdle, StClear: begin
        w_count_d = '0;
        w_clear_d = 1'b1;
        w_busy_d  = (w_state_d == StClear);
        w_done_d  = 1'b0;
        w_idx_d   = '0;
      end
      StRun: begin
        w_clear_d = 1'b0;
        w_busy_d  = 1'b1;
        w_done_d  = 1'b0;
        if (r_state == StClear) begin
          w_idx_d   = '0;
          w_count_d = r_table[0];
        end else if (bus.en) begin
          if (w_last) begin
            w_idx_d   = '0;
            w_count_d = r_table[0];
            w_wrap_d  = 1'b1;
          end else begin
            w_idx_d   = w_idx_inc;
            w_count_d = r_table[w_idx_inc];
          end
        end
      end
      StDone: begin
        w_clear_d = 1'b0;
        w_busy_d  = 1'b0;
        w_done_d  = 1'b1;
      end
      default: ;
    endcase
    if (w_state_d == StClear) begin
      w_mode_d = bus.mode;
      w_len_d  = w_len_clamp;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
      r_clear <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
      r_idx   <= '0;
      r_mode  <= 1'b0;
      r_len   <= LenOne;
    end else begin
      r_count <= w_count_d;
      r_clear <= w_clear_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
      r_wrap  <= w_wrap_d;
      r_idx   <= w_idx_d;
      r_mode  <= w_mode_d;
      r_len   <= w_len_d;
    end
  end

  // Reads above see the pre-edge contents, so a same-edge write shows up one edge later
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_table[i] <= WIDTH'(i);
      end
    end else if (bus.prog_we && w_addr_ok) begin
      r_table[bus.prog_addr] <= bus.prog_data;
    end
  end

  assign bus.count = r_count;
  assign bus.clear = r_clear;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.wrap  = r_wrap;

endmodule

// File: tb/tb_seq_ctrl_param.sv
// Directed bench for seq_ctrl_param: loop, one-shot, hold, len clamping, same-edge write,
// abort-vs-start and mid-run reset, with hand-computed expected values.
module tb_seq_ctrl_param;
  localparam int unsigned WIDTH = 3;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  seq_ctrl_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) bus ();

  seq_ctrl_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int loop_cnt [9]  = '{0, 1, 2, 3, 4, 5, 0, 1, 2};
  int loop_wrap [9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
  int prog_val [6]  = '{5, 5, 2, 2, 6, 6};
  int long_cnt [8]  = '{5, 5, 2, 2, 6, 6, 6, 7};

  task automatic check_eq(input string tag, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input int c, input int clr, input int b,
                            input int d, input int w);
    check_eq({tag, "_count"}, int'(bus.count), c);
    check_eq({tag, "_clear"}, int'(bus.clear), clr);
    check_eq({tag, "_busy"},  int'(bus.busy),  b);
    check_eq({tag, "_done"},  int'(bus.done),  d);
    check_eq({tag, "_wrap"},  int'(bus.wrap),  w);
  endtask

  task automatic do_start(input logic m, input logic [AW:0] l);
    bus.mode  = m;
    bus.len   = l;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.en        = 1'b0;
    bus.mode      = 1'b0;
    bus.len       = '0;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    tick();
    tick();
    check_outs("reset", 0, 1, 0, 0, 0);

    // Loop over default table, len 6
    rst_n  = 1'b1;
    bus.en = 1'b1;
    do_start(1'b0, 4'd6);
    check_outs("loop_clear", 0, 1, 1, 0, 0);
    for (int i = 0; i < 9; i++) begin
      tick();
      check_eq($sformatf("loop_cnt%0d", i), int'(bus.count), loop_cnt[i]);
      check_eq($sformatf("loop_wrap%0d", i), int'(bus.wrap), loop_wrap[i]);
      check_eq($sformatf("loop_clr%0d", i), int'(bus.clear), 0);
    end

    // Hold with en low
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outs($sformatf("hold%0d", i), 2, 0, 1, 0, 0);
    end
    bus.en = 1'b1;
    tick();
    check_eq("resume_cnt", int'(bus.count), 3);

    // Reprogram while running (en low keeps count parked)
    bus.en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.prog_we   = 1'b1;
      bus.prog_addr = AW'(i);
      bus.prog_data = WIDTH'(prog_val[i]);
      tick();
    end
    bus.prog_we = 1'b0;
    check_eq("prog_hold_cnt", int'(bus.count), 3);

    // One-shot over programmed entries
    bus.en = 1'b1;
    do_start(1'b1, 4'd6);
    check_outs("os_clear", 0, 1, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq($sformatf("os_cnt%0d", i), int'(bus.count), prog_val[i]);
      check_eq($sformatf("os_done%0d", i), int'(bus.done), 0);
    end
    tick();
    check_outs("os_done", 6, 0, 0, 1, 0);
    tick();
    check_outs("os_done_hold", 6, 0, 0, 1, 0);

    // len=0 clamps to 1: wrap every enabled cycle
    do_start(1'b0, 4'd0);
    check_outs("len0_clear", 0, 1, 1, 0, 0);
    tick();
    check_outs("len0_first", 5, 0, 1, 0, 0);
    tick();
    check_outs("len0_wrap_a", 5, 0, 1, 0, 1);
    tick();
    check_outs("len0_wrap_b", 5, 0, 1, 0, 1);

    // len=DEPTH+3 clamps to DEPTH, restart from RUN
    do_start(1'b1, 4'(DEPTH + 3));
    check_outs("lenmax_clear", 0, 1, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq($sformatf("lenmax_cnt%0d", i), int'(bus.count), long_cnt[i]);
      check_eq($sformatf("lenmax_done%0d", i), int'(bus.done), 0);
    end
    tick();
    check_outs("lenmax_done", 7, 0, 0, 1, 0);

    // Write entry 1 on the same edge that reads it
    do_start(1'b0, 4'd3);
    tick();
    check_eq("rw_idx0", int'(bus.count), 5);
    bus.prog_we   = 1'b1;
    bus.prog_addr = 3'd1;
    bus.prog_data = 3'd7;
    tick();
    bus.prog_we = 1'b0;
    check_eq("rw_old", int'(bus.count), 5);
    tick();
    check_eq("rw_idx2", int'(bus.count), 2);
    tick();
    check_eq("rw_wrap_cnt", int'(bus.count), 5);
    check_eq("rw_wrap", int'(bus.wrap), 1);
    tick();
    check_eq("rw_new", int'(bus.count), 7);

    // abort together with start in RUN
    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    check_outs("abort", 0, 1, 0, 0, 0);
    tick();
    check_outs("abort_idle", 0, 1, 0, 0, 0);
    do_start(1'b0, 4'd3);
    check_outs("restart_clear", 0, 1, 1, 0, 0);
    tick();
    check_outs("restart_run", 5, 0, 1, 0, 0);

    // Reset mid-run with a competing table write
    tick();
    rst_n         = 1'b0;
    bus.prog_we   = 1'b1;
    bus.prog_addr = 3'd0;
    bus.prog_data = 3'd3;
    tick();
    check_outs("rst_mid", 0, 1, 0, 0, 0);
    rst_n       = 1'b1;
    bus.prog_we = 1'b0;
    do_start(1'b0, 4'd6);
    tick();
    check_eq("rst_tab0", int'(bus.count), 0);
    tick();
    check_eq("rst_tab1", int'(bus.count), 1);
    tick();
    check_eq("rst_tab2", int'(bus.count), 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/seq_ctrl_param.md
# seq_ctrl_param

Parametrised sequence controller that drives a counter through a programmable list of states instead of a fixed hard-coded sequence. It holds a DEPTH-entry table of WIDTH-bit values and steps through the first `len` entries, one per enabled clock. Each cycle it presents the current entry on `count` and asserts `clear` at sequence start. It sits between the test/stimulus logic and the random-sequence counter datapath, and it supports run-time reprogramming, loop or one-shot mode, and abort.

## Interface
- WIDTH, 3: bit width of each sequence value and of `count`.
- DEPTH, 8: number of table entries (≥2).
- AW, $clog2(DEPTH): table address / length index width.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  pulse: begin (or restart) the sequence.
- abort  in  1  pulse: stop and return to idle.
- en  in  1  advance enable while running.
- mode  in  1  0 = loop, 1 = one-shot; sampled on start.
- len  in  AW+1  active entry count; sampled on start.
- prog_we  in  1  table write strobe.
- prog_addr  in  AW  table write address.
- prog_data  in  WIDTH  table write data.
- count  out  WIDTH  current sequence value (registered).
- clear  out  1  counter clear (registered).
- busy  out  1  high in CLEAR or RUN.
- done  out  1  high in DONE (one-shot complete).
- wrap  out  1  one-cycle pulse on a loop wrap.

## Operation
- States: IDLE, CLEAR, RUN, DONE.
- Reset (rst_n=0 at an edge): state=IDLE, count=0, clear=1, busy=0, done=0, wrap=0, idx=0, mode_q=0, len_q=1. Table entry i is set to i mod 2^WIDTH.
- IDLE: clear=1, count=0. On start → CLEAR.
- CLEAR: lasts one cycle with clear=1, count=0, busy=1, idx=0. Then unconditionally → RUN with count=table[0], clear=0.
- RUN:
  - en=0: all outputs hold.
  - en=1 and idx<len_q-1: idx+1, count=table[idx+1].
  - en=1 and idx=len_q-1, mode_q=0: idx=0, count=table[0], wrap=1 for one cycle.
  - en=1 and idx=len_q-1, mode_q=1: → DONE, count holds the last entry.
- DONE: done=1, busy=0, count holds. On start → CLEAR.
- start in RUN or CLEAR restarts: → CLEAR, and mode/len are re-sampled.
- abort in any non-IDLE state → IDLE (count=0, clear=1) on the next edge. abort has priority over start and en.
- len clamping at start: len=0 is taken as 1; len>DEPTH is taken as DEPTH. len_q=1 in loop mode gives count=table[0] every cycle and wrap on every enabled cycle.
- Programming:
  - prog_we writes table[prog_addr]=prog_data at the edge, legal in any state.
  - prog_addr≥DEPTH is ignored.
  - A write and a read of the same entry at the same edge returns the old value. The new value is visible from the next edge.
- rst_n has priority over everything, including prog_we. Reset mid-run returns to IDLE and restores the default table.

## Timing
- Every output is a register; there are no combinational paths from input to output.
- start sampled at edge k: clear=1 and busy=1 during cycle k..k+1; count=table[0] and clear=0 after edge k+1.
- Advance latency: en sampled at edge k changes count after edge k.
- wrap is high for exactly one cycle per wrap. In DONE, done stays high until start, abort or reset.
- Throughput: one new value per enabled cycle. The wrap does not insert a bubble.

## Test plan
- Reset → default table, len=6, mode=0, start, en=1 continuously → count 0,1,2,3,4,5,0,1…, wrap pulse on each return to 0, clear high only in the CLEAR cycle.
- Program table[0..5]=5,5,2,2,6,6, len=6, mode=1, start, en=1 → count 5,5,2,2,6,6, then done=1 with count=6 held and busy=0.
- Toggle en=0 for 3 cycles mid-RUN → count and idx frozen, no wrap, sequence resumes unchanged.
- Apply len=0 and len=DEPTH+3 → run lengths of 1 and DEPTH respectively. Write table[1]=7 on the same edge that reads entry 1 → old value appears, then 7 on the next pass.
- Assert abort and start together in RUN → IDLE, count=0, clear=1. Start on the following cycle → normal CLEAR→RUN.
- Drop rst_n for one edge mid-RUN after reprogramming → IDLE outputs, default table restored, first start yields count=0.
